// File: rtl/muldiv_ctrl.sv
// HI/LO controller for MULT/MULTU/DIV/DIVU/MTHI/MTLO running beside EXE.
// Sequences an external fixed-latency multiplier and an external unsigned
// divider, applies the sign fix-up to their results and owns HI/LO.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        req_valid_i,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_src0_i,
  input  logic [31:0] req_src1_i,
  output logic        req_ready_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mul_start_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic [63:0] mul_prod_i,
  output logic        div_start_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  output logic        div_abort_o,
  input  logic        div_done_i,
  input  logic [31:0] div_quot_i,
  input  logic [31:0] div_rem_i
);

  typedef enum logic [2:0] {
    IDLE, MUL_ISSUE, MUL_WAIT, DIV_ISSUE, DIV_WAIT
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
  } op_t;

  state_t      state, state_nxt;
  op_t         op;
  logic [31:0] hi, lo;
  logic [31:0] mag_a, mag_b;
  logic [3:0]  cnt;
  logic        neg;     // product sign for mul, quotient sign for div
  logic        rneg;    // remainder sign (div only)
  logic        accept, is_mul, is_div, is_signed, div_zero, load;
  logic        mul_done, div_fin;

  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

  assign op        = op_t'(req_op_i);
  assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign div_zero  = (req_src1_i == 32'd0);
  assign accept    = req_valid_i && (state == IDLE) && !flush_i;
  assign load      = accept && (is_mul || (is_div && !div_zero));

  assign hi_o           = hi;
  assign lo_o           = lo;
  assign mul_a_o        = mag_a;
  assign mul_b_o        = mag_b;
  assign div_dividend_o = mag_a;
  assign div_divisor_o  = mag_b;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state, completion strobes and output decodes; flush overrides all
  always_comb begin
    state_nxt   = state;
    mul_done    = 1'b0;
    div_fin     = 1'b0;
    req_ready_o = (state == IDLE);
    busy_o      = (state != IDLE);
    mul_start_o = 1'b0;
    div_start_o = 1'b0;
    div_abort_o = 1'b0;
    case (state)
      IDLE: begin
        if (load) state_nxt = is_mul ? MUL_ISSUE : DIV_ISSUE;
      end
      MUL_ISSUE: begin
        mul_start_o = !flush_i;
        state_nxt   = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (cnt == 4'd1) begin
          mul_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      DIV_ISSUE: begin
        div_start_o = !flush_i;
        div_abort_o = flush_i;
        state_nxt   = DIV_WAIT;
      end
      DIV_WAIT: begin
        div_abort_o = flush_i;
        if (div_done_i) begin
          div_fin   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i) begin
      state_nxt = IDLE;
      mul_done  = 1'b0;
      div_fin   = 1'b0;
    end
  end

  // Operand latch, latency counter and HI/LO write-back
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi    <= '0;
      lo    <= '0;
      mag_a <= '0;
      mag_b <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      rneg  <= 1'b0;
    end else begin
      if (accept && (op == OP_MTHI)) hi <= req_src0_i;
      if (accept && (op == OP_MTLO)) lo <= req_src0_i;
      if (load) begin
        mag_a <= magnitude(req_src0_i, is_signed);
        mag_b <= magnitude(req_src1_i, is_signed);
        neg   <= is_signed && (req_src0_i[31] ^ req_src1_i[31]);
        rneg  <= is_signed && req_src0_i[31];
      end
      if (state == MUL_ISSUE)     cnt <= 4'(MUL_LAT);
      else if (state == MUL_WAIT) cnt <= cnt - 4'd1;
      if (mul_done) {hi, lo} <= neg ? (~mul_prod_i + 64'd1) : mul_prod_i;
      if (div_fin) begin
        lo <= neg  ? (~div_quot_i + 32'd1) : div_quot_i;
        hi <= rneg ? (~div_rem_i  + 32'd1) : div_rem_i;
      end
    end
  end

endmodule
